// File: rtl/v850_pkg.sv
// Shared types, opcode constants and the instruction-length rule for the V850 fetch/decode slice.
package v850_pkg;

    typedef enum logic [3:0] {
        CLS_NONE  = 4'd0,
        ALU_RR    = 4'd1,
        ALU_IMM5  = 4'd2,
        ALU_IMM16 = 4'd3,
        BCOND     = 4'd4,
        CALLT     = 4'd5,
        EXT       = 4'd6,
        MOVI32    = 4'd7,
        ILLEGAL   = 4'd8
    } ins_class_t;

    localparam logic [5:0] OP_ADD_RR = 6'b001110;
    localparam logic [5:0] OP_CMP_RR = 6'b001111;
    localparam logic [5:0] OP_AND_RR = 6'b001010;
    localparam logic [5:0] OP_ADD_I5 = 6'b010010;
    localparam logic [5:0] OP_CMP_I5 = 6'b010011;
    localparam logic [5:0] OP_ADDI   = 6'b110000;
    localparam logic [5:0] OP_ANDI   = 6'b110110;
    localparam logic [5:0] OP_MOVI32 = 6'b110001;
    localparam logic [5:0] OP_EXT    = 6'b111111;

    // Length in halfwords, judged from the first halfword only.
    function automatic logic [1:0] insn_len(input logic [15:0] h);
        if (h[10:5] == OP_MOVI32 && h[15:11] == 5'd0)
            return 2'd3;
        else if (h[10:9] == 2'b11)
            return 2'd2;
        else
            return 2'd1;
    endfunction

endpackage

// File: rtl/v850_hw_queue.sv
// Halfword circular buffer: FETCH_HW-wide push, 3-halfword peek at the head, pop of 1..3.
module v850_hw_queue #(
    parameter int FETCH_HW    = 2,
    parameter int QUEUE_DEPTH = 8,
    localparam int AW         = $clog2(QUEUE_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic [16*FETCH_HW-1:0] push_data,
    input  logic                   pop,
    input  logic [1:0]             pop_len,
    output logic [47:0]            peek,
    output logic [AW:0]            count,
    output logic [AW:0]            free
);

    logic [15:0]   mem_reg [QUEUE_DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic [AW-1:0] wr_idx [FETCH_HW];
    logic [AW-1:0] rd_idx [3];

    // Index arithmetic is done at AW bits so it wraps around the end of storage.
    generate
        for (genvar gi = 0; gi < FETCH_HW; gi++) begin : g_wr
            assign wr_idx[gi] = wr_ptr_reg[AW-1:0] + AW'(gi);
        end
        for (genvar gi = 0; gi < 3; gi++) begin : g_rd
            assign rd_idx[gi]         = rd_ptr_reg[AW-1:0] + AW'(gi);
            assign peek[16*gi +: 16]  = mem_reg[rd_idx[gi]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < FETCH_HW; i++)
                mem_reg[wr_idx[i]] <= push_data[16*i +: 16];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(FETCH_HW);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(pop_len);
        end
    end

    assign count = wr_ptr_reg - rd_ptr_reg;
    assign free  = (AW+1)'(QUEUE_DEPTH) - count;

endmodule

// File: rtl/v850_fetch_decode.sv
// V850 fetch/decode front end: queues fetched halfwords, sizes and classifies the head
// instruction and issues one registered decoded instruction per cycle.
module v850_fetch_decode
    import v850_pkg::*;
#(
    parameter int FETCH_HW    = 2,
    parameter int QUEUE_DEPTH = 8,
    parameter int PC_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [PC_W-1:0]        flush_pc,
    input  logic                   fetch_valid,
    output logic                   fetch_ready,
    input  logic [16*FETCH_HW-1:0] fetch_data,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [47:0]            dec_insn,
    output logic [1:0]             dec_len,
    output logic [PC_W-1:0]        dec_pc,
    output logic [3:0]             dec_class,
    output logic [4:0]             dec_reg1,
    output logic [4:0]             dec_reg2,
    output logic [4:0]             dec_reg3
);

    localparam int AW = $clog2(QUEUE_DEPTH);

    logic [47:0]     q_peek;
    logic [AW:0]     q_count;
    logic [AW:0]     q_free;
    logic [15:0]     head;
    logic [1:0]      head_len;
    logic            can_load;
    logic            have_insn;
    logic            push;
    logic            pop;
    logic [AW+1:0]   free_next;
    logic [47:0]     cand_insn;

    logic            fetch_ready_reg;
    logic            dec_valid_reg;
    logic [47:0]     dec_insn_reg;
    logic [1:0]      dec_len_reg;
    logic [PC_W-1:0] dec_pc_reg;
    ins_class_t      dec_class_reg;
    logic [PC_W-1:0] pc_reg;

    function automatic ins_class_t classify(input logic [15:0] h, input logic [1:0] len);
        if (h[10:5] == OP_ADD_RR || h[10:5] == OP_CMP_RR || h[10:5] == OP_AND_RR)
            return ALU_RR;
        else if (h[10:5] == OP_ADD_I5 || h[10:5] == OP_CMP_I5)
            return ALU_IMM5;
        else if (h[10:5] == OP_ADDI || h[10:5] == OP_ANDI)
            return ALU_IMM16;
        else if (h[10:7] == 4'b1011)
            return BCOND;
        else if (h[15:6] == 10'b0000001000)
            return CALLT;
        else if (h[10:5] == OP_EXT)
            return EXT;
        else if (len == 2'd3)
            return MOVI32;
        else
            return ILLEGAL;
    endfunction

    v850_hw_queue #(
        .FETCH_HW    (FETCH_HW),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (push),
        .push_data (fetch_data),
        .pop       (pop),
        .pop_len   (head_len),
        .peek      (q_peek),
        .count     (q_count),
        .free      (q_free)
    );

    assign head      = q_peek[15:0];
    assign head_len  = insn_len(head);
    assign can_load  = !dec_valid_reg || dec_ready;
    // Issue looks only at halfwords already stored, never at this cycle's beat.
    assign have_insn = q_count >= (AW+1)'(head_len);
    assign push      = fetch_valid && fetch_ready_reg && !flush;
    assign pop       = !flush && can_load && have_insn;

    always_comb begin
        case (head_len)
            2'd3:    cand_insn = q_peek;
            2'd2:    cand_insn = {16'h0, q_peek[31:0]};
            default: cand_insn = {32'h0, q_peek[15:0]};
        endcase
    end

    always_comb begin
        free_next = {1'b0, q_free};
        if (push)
            free_next = free_next - (AW+2)'(FETCH_HW);
        if (pop)
            free_next = free_next + (AW+2)'(head_len);
        if (flush)
            free_next = (AW+2)'(QUEUE_DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_ready_reg <= 1'b1;
            dec_valid_reg   <= 1'b0;
            dec_insn_reg    <= '0;
            dec_len_reg     <= 2'd1;
            dec_pc_reg      <= '0;
            dec_class_reg   <= CLS_NONE;
            pc_reg          <= '0;
        end else begin
            fetch_ready_reg <= free_next >= (AW+2)'(FETCH_HW);
            if (flush) begin
                dec_valid_reg <= 1'b0;
                dec_class_reg <= CLS_NONE;
                pc_reg        <= flush_pc & ~PC_W'(1);
            end else if (can_load) begin
                if (have_insn) begin
                    dec_valid_reg <= 1'b1;
                    dec_insn_reg  <= cand_insn;
                    dec_len_reg   <= head_len;
                    dec_pc_reg    <= pc_reg;
                    dec_class_reg <= classify(head, head_len);
                    pc_reg        <= pc_reg + PC_W'({head_len, 1'b0});
                end else begin
                    dec_valid_reg <= 1'b0;
                    dec_class_reg <= CLS_NONE;
                end
            end
        end
    end

    assign fetch_ready = fetch_ready_reg;
    assign dec_valid   = dec_valid_reg;
    assign dec_insn    = dec_insn_reg;
    assign dec_len     = dec_len_reg;
    assign dec_pc      = dec_pc_reg;
    assign dec_class   = dec_class_reg;
    // Upper halfwords of a short instruction are zero, so reg3 reads 0 for 16-bit forms.
    assign dec_reg1    = dec_insn_reg[4:0];
    assign dec_reg2    = dec_insn_reg[15:11];
    assign dec_reg3    = dec_insn_reg[31:27];

endmodule

// File: tb/tb_v850_fetch_decode.sv
// Directed bench for v850_fetch_decode with hand-computed expectations (FETCH_HW=2, depth 8).
module tb_v850_fetch_decode;
    import v850_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [47:0] dec_insn;
    logic [1:0]  dec_len;
    logic [31:0] dec_pc;
    logic [3:0]  dec_class;
    logic [4:0]  dec_reg1;
    logic [4:0]  dec_reg2;
    logic [4:0]  dec_reg3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    v850_fetch_decode #(
        .FETCH_HW    (2),
        .QUEUE_DEPTH (8),
        .PC_W        (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_data  (fetch_data),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_insn    (dec_insn),
        .dec_len     (dec_len),
        .dec_pc      (dec_pc),
        .dec_class   (dec_class),
        .dec_reg1    (dec_reg1),
        .dec_reg2    (dec_reg2),
        .dec_reg3    (dec_reg3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_issue(input string tag, input logic [31:0] pc, input logic [1:0] len,
                                input logic [3:0] cls, input logic [47:0] insn);
        logic [4:0] r3;
        r3 = (len == 2'd1) ? 5'd0 : insn[31:27];
        $display("issue %s: pc=%h len=%0d class=%0d insn=%h", tag, dec_pc, dec_len, dec_class, dec_insn);
        chk({tag, ".valid"}, dec_valid, 1'b1);
        chk({tag, ".pc"},    dec_pc,    pc);
        chk({tag, ".len"},   dec_len,   len);
        chk({tag, ".class"}, dec_class, cls);
        chk({tag, ".insn"},  dec_insn,  insn);
        chk({tag, ".reg1"},  dec_reg1,  insn[4:0]);
        chk({tag, ".reg2"},  dec_reg2,  insn[15:11]);
        chk({tag, ".reg3"},  dec_reg3,  r3);
    endtask

    task automatic expect_idle(input string tag);
        $display("idle %s: valid=%0d class=%0d", tag, dec_valid, dec_class);
        chk({tag, ".valid"}, dec_valid, 1'b0);
        chk({tag, ".class"}, dec_class, CLS_NONE);
    endtask

    task automatic beat(input logic [15:0] h0, input logic [15:0] h1);
        fetch_valid = 1'b1;
        fetch_data  = {h1, h0};
        tick();
        fetch_valid = 1'b0;
    endtask

    function automatic logic [15:0] seq_hw(input int k);
        return 16'h01C0 | 16'(k);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        acc;
        logic        have_snap;
        logic [47:0] snap_insn;
        logic [31:0] snap_pc;
        int          k;

        rst_n = 1'b0; flush = 1'b0; flush_pc = '0;
        fetch_valid = 1'b0; fetch_data = '0; dec_ready = 1'b0;
        tick(); tick();
        chk("rst.valid", dec_valid, 1'b0);
        chk("rst.ready", fetch_ready, 1'b1);
        chk("rst.len",   dec_len, 2'd1);
        chk("rst.class", dec_class, CLS_NONE);
        chk("rst.pc",    dec_pc, 32'h0);
        chk("rst.insn",  dec_insn, 48'h0);
        rst_n = 1'b1;
        tick(); tick();
        expect_idle("post_rst");
        chk("post_rst.ready", fetch_ready, 1'b1);

        // Two 16-bit instructions after a redirect to 0x100
        flush = 1'b1; flush_pc = 32'h100;
        tick();
        flush = 1'b0;
        dec_ready = 1'b1;
        beat(16'h01C3, 16'h0A42);
        expect_idle("pair.latency");
        tick();
        expect_issue("pair.add", 32'h100, 2'd1, ALU_RR, 48'h01C3);
        chk("pair.add.r1", dec_reg1, 5'd3);
        tick();
        expect_issue("pair.addi5", 32'h102, 2'd1, ALU_IMM5, 48'h0A42);
        tick();
        expect_idle("pair.drain");

        // 32-bit ADDI split across two beats
        beat(16'h01C3, 16'h0E01);
        expect_idle("split.beat1");
        tick();
        expect_issue("split.lead", 32'h104, 2'd1, ALU_RR, 48'h01C3);
        tick();
        expect_idle("split.wait1");
        tick();
        expect_idle("split.wait2");
        beat(16'h1234, 16'h0A42);
        expect_idle("split.beat2");
        tick();
        expect_issue("split.addi", 32'h106, 2'd2, ALU_IMM16, 48'h12340E01);
        chk("split.addi.r3", dec_reg3, 5'd2);
        tick();
        expect_issue("split.tail", 32'h10A, 2'd1, ALU_IMM5, 48'h0A42);
        tick();
        expect_idle("split.drain");

        // 48-bit MOV imm32, read wraps across the end of the queue
        beat(16'h0621, 16'h5678);
        expect_idle("mov.beat1");
        beat(16'h1234, 16'h01C3);
        expect_idle("mov.beat2");
        tick();
        expect_issue("mov.imm32", 32'h10C, 2'd3, MOVI32, 48'h123456780621);
        chk("mov.r3", dec_reg3, 5'd10);
        tick();
        expect_issue("mov.next", 32'h112, 2'd1, ALU_RR, 48'h01C3);
        tick();
        expect_idle("mov.drain");

        // Back-pressure: stream while execute stalls, then drain in order
        dec_ready = 1'b0;
        k = 0;
        have_snap = 1'b0;
        snap_insn = '0;
        snap_pc = '0;
        for (int c = 0; c < 12; c++) begin
            fetch_valid = 1'b1;
            fetch_data  = {seq_hw(k + 1), seq_hw(k)};
            acc = fetch_ready;
            tick();
            if (acc)
                k += 2;
            if (have_snap) begin
                chk("hold.valid", dec_valid, 1'b1);
                chk("hold.insn",  dec_insn, snap_insn);
                chk("hold.pc",    dec_pc, snap_pc);
            end else if (dec_valid) begin
                have_snap = 1'b1;
                snap_insn = dec_insn;
                snap_pc   = dec_pc;
            end
        end
        fetch_valid = 1'b0;
        chk("hold.started", have_snap, 1'b1);
        chk("hold.ready_low", fetch_ready, 1'b0);
        chk("hold.accepted", k, 8);
        dec_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            expect_issue($sformatf("hold.drain%0d", j), 32'h114 + 32'(2 * j), 2'd1, ALU_RR,
                         {32'h0, seq_hw(j)});
            tick();
        end
        expect_idle("hold.empty");
        chk("hold.ready_back", fetch_ready, 1'b1);

        // Flush in the same cycle as a fetch beat and a handshake
        dec_ready = 1'b0;
        beat(16'h01C3, 16'h0A42);
        tick();
        expect_issue("flush.pre", 32'h124, 2'd1, ALU_RR, 48'h01C3);
        flush = 1'b1; flush_pc = 32'h203;
        fetch_valid = 1'b1; fetch_data = {16'h0A43, 16'h01C4};
        dec_ready = 1'b1;
        tick();
        flush = 1'b0; fetch_valid = 1'b0;
        expect_idle("flush.edge");
        tick();
        expect_idle("flush.dropped");
        chk("flush.ready", fetch_ready, 1'b1);
        beat(16'h01C5, 16'h0A45);
        tick();
        expect_issue("flush.first", 32'h202, 2'd1, ALU_RR, 48'h01C5);
        tick();
        expect_issue("flush.second", 32'h204, 2'd1, ALU_IMM5, 48'h0A45);

        // Asynchronous reset in the middle of a held instruction
        dec_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", dec_valid, 1'b0);
        chk("arst.pc",    dec_pc, 32'h0);
        chk("arst.insn",  dec_insn, 48'h0);
        chk("arst.ready", fetch_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        dec_ready = 1'b1;
        beat(16'h01C3, 16'h0A42);
        tick();
        expect_issue("arst.resume0", 32'h0, 2'd1, ALU_RR, 48'h01C3);
        tick();
        expect_issue("arst.resume1", 32'h2, 2'd1, ALU_IMM5, 48'h0A42);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
